// File: rtl/timer_pkg.sv
// Shared register map, TCR bit positions and the TCR layout for the APB timer.
// Optional PWM compare (register CCR, output pwm_out) is built when TIMER_PWM_EN is defined.
package timer_pkg;

  localparam logic [2:0] TCR_OFS    = 3'd0;
  localparam logic [2:0] PSC_OFS    = 3'd1;
  localparam logic [2:0] ARR_OFS    = 3'd2;
  localparam logic [2:0] TCNT_OFS   = 3'd3;
  localparam logic [2:0] STATUS_OFS = 3'd4;
  localparam logic [2:0] CCR_OFS    = 3'd5;

  localparam int TCR_EN_BIT  = 0;
  localparam int TCR_CLR_BIT = 1;
  localparam int TCR_ARE_BIT = 2;
  localparam int TCR_IE_BIT  = 3;

  typedef struct packed {
    logic ie;
    logic are;
    logic clr;
    logic en;
  } tcr_t;

endpackage

// File: rtl/apb_timer_periph_if.sv
// APB bus signals between the MCU master and the timer slave.
interface apb_timer_periph_if;

  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWRITE, PENABLE, PSEL, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PENABLE, PSEL, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: emits one tick every psc+1 enabled cycles; clr restarts it and swallows the tick.
module timer_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt;

  assign tick = en & ~clr & (psc_cnt == psc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt <= '0;
    end else if (clr || tick) begin
      psc_cnt <= '0;
    end else if (en) begin
      psc_cnt <= psc_cnt + PSC_W'(1);
    end
  end

endmodule

// File: rtl/apb_timer_periph.sv
// APB timer: prescaled 32-bit up-counter with compare/auto-reload, sticky match flag and irq.
// Define TIMER_PWM_EN to add the CCR register and the pwm_out compare output.
module apb_timer_periph
  import timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_timer_periph_if.slave   apb,
  output logic                irq
`ifdef TIMER_PWM_EN
  ,
  output logic                pwm_out
`endif
);

  logic [2:0]       ofs;
  logic             setup;
  logic             wr_en;
  logic             wr_tcr, wr_psc, wr_arr, wr_status;
  tcr_t             tcr, wr_tcr_val;
  logic [PSC_W-1:0] psc;
  logic [CNT_W-1:0] arr;
  logic [CNT_W-1:0] tcnt;
  logic             mf;
  logic             clr;
  logic             en_eff;
  logic             tick;
  logic             match;
  logic             pready_q;
  logic [31:0]      prdata_q;
  logic [31:0]      rd_data;
  logic             unused_addr;

  assign ofs         = apb.PADDR[4:2];
  assign unused_addr = ^{apb.PADDR[31:5], apb.PADDR[1:0]};
  assign setup       = apb.PSEL & ~apb.PENABLE;
  assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE & pready_q;
  assign wr_tcr      = wr_en & (ofs == TCR_OFS);
  assign wr_psc      = wr_en & (ofs == PSC_OFS);
  assign wr_arr      = wr_en & (ofs == ARR_OFS);
  assign wr_status   = wr_en & (ofs == STATUS_OFS);

  assign wr_tcr_val.en  = apb.PWDATA[TCR_EN_BIT];
  assign wr_tcr_val.clr = apb.PWDATA[TCR_CLR_BIT];
  assign wr_tcr_val.are = apb.PWDATA[TCR_ARE_BIT];
  assign wr_tcr_val.ie  = apb.PWDATA[TCR_IE_BIT];

  // A TCR write that drops EN must also block a tick landing in the same cycle.
  assign clr    = wr_tcr & wr_tcr_val.clr;
  assign en_eff = tcr.en & ~(wr_tcr & ~wr_tcr_val.en);
  assign match  = (tcnt == arr);

  timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk   (PCLK),
    .rst_n (PRESET),
    .en    (en_eff),
    .clr   (clr),
    .psc   (psc),
    .tick  (tick)
  );

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      tcr <= '0;
    end else if (wr_tcr) begin
      tcr     <= wr_tcr_val;
      tcr.clr <= 1'b0;
    end else if (tick && match && !tcr.are) begin
      tcr.en <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      psc <= '0;
      arr <= '1;
    end else begin
      if (wr_psc) psc <= apb.PWDATA[PSC_W-1:0];
      if (wr_arr) arr <= apb.PWDATA[CNT_W-1:0];
    end
  end

  // Counting past a lowered ARR wraps through all ones without a match.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      tcnt <= '0;
    end else if (clr) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= match ? '0 : tcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      mf <= 1'b0;
    end else if (tick && match) begin
      mf <= 1'b1;
    end else if (wr_status && apb.PWDATA[0]) begin
      mf <= 1'b0;
    end
  end

  assign irq = mf & tcr.ie;

`ifdef TIMER_PWM_EN
  logic [CNT_W-1:0] ccr;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ccr     <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (wr_en && (ofs == CCR_OFS)) ccr <= apb.PWDATA[CNT_W-1:0];
      pwm_out <= tcr.en & (tcnt < ccr);
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    case (ofs)
      TCR_OFS:    rd_data[3:0] = tcr;
      PSC_OFS:    rd_data      = 32'(psc);
      ARR_OFS:    rd_data      = 32'(arr);
      TCNT_OFS:   rd_data      = 32'(tcnt);
      STATUS_OFS: rd_data[0]   = mf;
`ifdef TIMER_PWM_EN
      CCR_OFS:    rd_data      = 32'(ccr);
`endif
      default:    rd_data      = '0;
    endcase
  end

  // Read data and PREADY launch at the edge ending setup, so both are valid in the access cycle.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      pready_q <= setup;
      if (setup && !apb.PWRITE) prdata_q <= rd_data;
    end
  end

  assign apb.PREADY = pready_q;
  assign apb.PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_timer_periph.sv
// Directed bench for apb_timer_periph: APB reads go through an expected-value queue.
module tb_apb_timer_periph;

  localparam logic [31:0] A_TCR    = 32'h00;
  localparam logic [31:0] A_PSC    = 32'h04;
  localparam logic [31:0] A_ARR    = 32'h08;
  localparam logic [31:0] A_TCNT   = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [31:0] A_CCR    = 32'h14;

  logic PCLK = 1'b0;
  logic PRESET;
  logic irq;
`ifdef TIMER_PWM_EN
  logic pwm_out;
`endif

  apb_timer_periph_if bus ();

  apb_timer_periph dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .apb     (bus),
    .irq     (irq)
`ifdef TIMER_PWM_EN
    ,
    .pwm_out (pwm_out)
`endif
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } sb_t;
  sb_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic wait_access(input string tag);
    int n = 0;
    while (bus.PREADY !== 1'b1 && n < 8) begin
      @(posedge PCLK);
      #1;
      n++;
    end
    check({tag, "_pready"}, 32'(bus.PREADY), 32'd1);
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    bus.PADDR   = addr;
    bus.PWDATA  = data;
    bus.PWRITE  = 1'b1;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    @(posedge PCLK);
    #1;
    bus.PENABLE = 1'b1;
    wait_access("wr");
    @(posedge PCLK);
    #1;
    bus_idle();
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    sb_t e;
    sb_q.push_back('{exp, tag});
    bus.PADDR   = addr;
    bus.PWRITE  = 1'b0;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    check({tag, "_setup_pready"}, 32'(bus.PREADY), 32'd0);
    @(posedge PCLK);
    #1;
    bus.PENABLE = 1'b1;
    wait_access(tag);
    e = sb_q.pop_front();
    check(e.tag, bus.PRDATA, e.exp);
    @(posedge PCLK);
    #1;
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    int c0;
    int n;
    int offs[4] = '{5, 8, 11, 14};

    PRESET     = 1'b0;
    bus.PADDR  = '0;
    bus.PWDATA = '0;
    bus_idle();
    @(posedge PCLK);
    #1;
    check("rst_pready", 32'(bus.PREADY), 32'd0);
    check("rst_prdata", bus.PRDATA, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    PRESET = 1'b1;

    // Reset values through the bus
    apb_read(A_TCR,    32'h0,        "rst_tcr");
    apb_read(A_PSC,    32'h0,        "rst_psc");
    apb_read(A_ARR,    32'hFFFFFFFF, "rst_arr");
    apb_read(A_TCNT,   32'h0,        "rst_tcnt");
    apb_read(A_STATUS, 32'h0,        "rst_status");

    // Free-running auto-reload, PSC=0, ARR=3: TCNT at setup offset k is k mod 4
    apb_write(A_ARR, 32'd3);
    apb_write(A_TCR, 32'h5);
    c0 = cyc;
    apb_read(A_TCNT, 32'd0, "tcnt_start");
    idle_until(c0 + 2);
    apb_read(A_STATUS, 32'd0, "mf_before_match");
    foreach (offs[i]) begin
      idle_until(c0 + offs[i]);
      apb_read(A_TCNT, 32'(offs[i] % 4), "tcnt_run");
    end
    idle_until(c0 + 17);
    apb_read(A_STATUS, 32'd1, "mf_after_match");
    apb_write(A_TCR, 32'h0);

    // One-shot with IE, PSC=2, ARR=1: irq exactly 6 cycles after the EN commit
    apb_write(A_PSC, 32'd2);
    apb_write(A_ARR, 32'd1);
    apb_write(A_TCR, 32'h2);
    apb_write(A_STATUS, 32'h1);
    check("irq_cleared", 32'(irq), 32'd0);
    apb_write(A_TCR, 32'h9);
    n = 0;
    while (irq !== 1'b1 && n < 20) begin
      @(posedge PCLK);
      #1;
      n++;
    end
    check("oneshot_latency", 32'(n), 32'd6);
    apb_read(A_TCR,    32'h8, "oneshot_en_off");
    apb_read(A_TCNT,   32'h0, "oneshot_tcnt");
    apb_read(A_STATUS, 32'h1, "oneshot_mf");
    apb_write(A_STATUS, 32'h1);
    check("irq_w1c", 32'(irq), 32'd0);
    apb_read(A_STATUS, 32'h0, "status_w1c");

    // Hardware MF set lands on the same edge as a STATUS W1C commit
    apb_write(A_PSC, 32'd0);
    apb_write(A_ARR, 32'd3);
    apb_write(A_TCR, 32'h7);
    c0 = cyc;
    idle_until(c0 + 2);
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h1, "mf_beats_w1c");

    // CLR mid-count
    apb_write(A_TCR, 32'h3);
    apb_read(A_TCNT, 32'h0, "clr_tcnt");
    apb_write(A_TCR, 32'h2);
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h0, "status_clear2");

    // Read-only and unmapped offsets
    apb_write(A_TCNT, 32'd5);
    apb_read(A_TCNT, 32'h0, "tcnt_ro");
    apb_write(32'h1C, 32'hFFFFFFFF);
    apb_read(32'h18, 32'h0, "unmapped_18");
    apb_read(A_TCR, 32'h0, "tcr_after_unmapped_wr");
`ifndef TIMER_PWM_EN
    apb_read(A_CCR, 32'h0, "no_ccr");
`else
    // PWM: ARR=9, CCR=3 gives 3 high cycles of every 10
    apb_write(A_ARR, 32'd9);
    apb_write(A_CCR, 32'd3);
    apb_read(A_CCR, 32'd3, "ccr_rd");
    apb_write(A_TCR, 32'h7);
    c0 = cyc;
    idle_until(c0 + 2);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (pwm_out === 1'b1) n++;
      @(posedge PCLK);
      #1;
    end
    check("pwm_duty", 32'(n), 32'd6);
    apb_write(A_CCR, 32'd0);
    idle_until(cyc + 2);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (pwm_out !== 1'b0) n++;
      @(posedge PCLK);
      #1;
    end
    check("pwm_ccr0", 32'(n), 32'd0);
    apb_write(A_TCR, 32'h2);
`endif

    // Asynchronous reset in the middle of an access with MF=1 and irq high
    apb_write(A_PSC, 32'd0);
    apb_write(A_ARR, 32'd1);
    apb_write(A_TCR, 32'hD);
    idle_until(cyc + 4);
    check("pre_rst_irq", 32'(irq), 32'd1);
    bus.PADDR   = A_ARR;
    bus.PWRITE  = 1'b0;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    @(posedge PCLK);
    #1;
    bus.PENABLE = 1'b1;
    check("pre_rst_pready", 32'(bus.PREADY), 32'd1);
    check("pre_rst_prdata", bus.PRDATA, 32'd1);
    #2;
    PRESET = 1'b0;
    #1;
    check("async_rst_pready", 32'(bus.PREADY), 32'd0);
    check("async_rst_prdata", bus.PRDATA, 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
`ifdef TIMER_PWM_EN
    check("async_rst_pwm", 32'(pwm_out), 32'd0);
`endif
    bus_idle();
    @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    apb_read(A_TCR,    32'h0,        "post_rst_tcr");
    apb_read(A_PSC,    32'h0,        "post_rst_psc");
    apb_read(A_ARR,    32'hFFFFFFFF, "post_rst_arr");
    apb_read(A_TCNT,   32'h0,        "post_rst_tcnt");
    apb_read(A_STATUS, 32'h0,        "post_rst_status");
`ifdef TIMER_PWM_EN
    apb_read(A_CCR,    32'h0,        "post_rst_ccr");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
